// File: rtl/button_debouncer_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and the
// glitch-counter width, plus small state decode helpers.
package debounce_pkg;

  localparam int GLITCH_W = 8;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    QUAL_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    QUAL_LOW  = 2'b10
  } state_t;

  // The accepted level is high while the FSM rests high or qualifies a fall.
  function automatic logic state_is_high(input state_t s);
    return (s == IDLE_HIGH) || (s == QUAL_LOW);
  endfunction

  function automatic logic state_is_settling(input state_t s);
    return (s == QUAL_HIGH) || (s == QUAL_LOW);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Bundle of the debouncer's button-side signals. There is no handshake:
// btn_out/settling/glitch_count are level outputs that are valid every cycle.
interface button_debouncer_if;
  import debounce_pkg::*;

  logic                btn_in;
  logic                btn_out;
  logic                settling;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    output btn_in,
    input  btn_out,
    input  settling,
    input  glitch_count
  );

  modport slave (
    input  btn_in,
    output btn_out,
    output settling,
    output glitch_count
  );
endinterface

// File: rtl/button_debouncer_sync_chain.sv
// Generic multi-flop synchronizer for asynchronous single-bit inputs.
// Only q (the last stage) is meant to be consumed by downstream logic.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizer + 4-state qualification FSM.
// Define DEBOUNCE_GLITCH_CNT_EN to build the saturating aborted-qualification counter.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  output logic                btn_out,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_out_q, btn_out_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      btn_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_out_q <= btn_out_d;
    end
  end

  // Counter is cleared on every qualification entry and parks at CNT_LAST,
  // so a bounce always restarts the full count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          state_d = QUAL_HIGH;
          cnt_d   = '0;
        end
      end
      QUAL_HIGH: begin
        if (!sync_q) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          state_d = QUAL_LOW;
          cnt_d   = '0;
        end
      end
      QUAL_LOW: begin
        if (sync_q) begin
          state_d = IDLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // btn_out gets its own flop loaded from the next state so it never
  // carries decode hazards into the downstream edge detector.
  assign btn_out_d = state_is_high(state_d);
  assign btn_out   = btn_out_q;
  assign settling  = state_is_settling(state_q);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                abort;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  assign abort = ((state_q == QUAL_HIGH) && !sync_q) ||
                 ((state_q == QUAL_LOW)  &&  sync_q);

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_count = glitch_q;
`else
  assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected btn_out edges and timed output probes are queued by the stimulus and checked by a monitor.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int SYNC = 2;
  localparam int DC   = 4;
  localparam int LAT  = SYNC + DC + 1;
  localparam int W    = 17;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
  } probe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_debouncer_if bus ();

  button_debouncer #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (bus.btn_in),
    .btn_out      (bus.btn_out),
    .settling     (bus.settling),
    .glitch_count (bus.glitch_count)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  probe_t       probe_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         mon_en = 1'b0;
  logic         prev_out = 1'b0;
  logic [W-1:0] e;
  probe_t       p;
  logic [7:0]   act;

  function automatic logic [7:0] g_exp(input int n);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.btn_out !== prev_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL btn_out_edge: unexpected change to %0b at cycle %0d", bus.btn_out, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((bus.btn_out !== e[0]) || (e[W-1:1] != 16'(cyc))) begin
            errors++;
            $display("FAIL btn_out_edge: got level %0b at cycle %0d, expected level %0b at cycle %0d",
                     bus.btn_out, cyc, e[0], e[W-1:1]);
          end
        end
        prev_out = bus.btn_out;
      end
      while ((probe_q.size() > 0) && (probe_q[0].cyc <= cyc)) begin
        p = probe_q.pop_front();
        case (p.kind)
          0:       act = {7'd0, bus.btn_out};
          1:       act = {7'd0, bus.settling};
          default: act = bus.glitch_count;
        endcase
        checks++;
        if ((p.cyc != cyc) || (act !== p.val)) begin
          errors++;
          $display("FAIL probe_%0s: cycle %0d actual %0d, expected %0d at cycle %0d",
                   (p.kind == 0) ? "btn_out" : (p.kind == 1) ? "settling" : "glitch_count",
                   cyc, act, p.val, p.cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_edge(input int at, input logic lvl);
    exp_q.push_back({16'(at), lvl});
  endtask

  task automatic probe(input int at, input int kind, input logic [7:0] v);
    probe_t t;
    t.cyc  = at;
    t.kind = kind;
    t.val  = v;
    probe_q.push_back(t);
  endtask

  // ---------------- stimulus ----------------
  int c;

  initial begin
    bus.btn_in = 1'b0;
    rst        = 1'b1;
    tick(1);
    prev_out = bus.btn_out;
    mon_en   = 1'b1;
    probe(cyc + 1, 0, 8'd0);
    probe(cyc + 1, 1, 8'd0);
    probe(cyc + 1, 2, 8'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // clean press
    c = cyc;
    bus.btn_in = 1'b1;
    exp_edge(c + LAT, 1'b1);
    probe(c + 2, 1, 8'd0);
    probe(c + 3, 1, 8'd1);
    probe(c + 6, 1, 8'd1);
    probe(c + 6, 0, 8'd0);
    probe(c + 7, 1, 8'd0);
    tick(10);

    // clean release
    c = cyc;
    bus.btn_in = 1'b0;
    exp_edge(c + LAT, 1'b0);
    probe(c + 3, 1, 8'd1);
    probe(c + 6, 0, 8'd1);
    probe(c + 7, 1, 8'd0);
    probe(c + 8, 2, g_exp(0));
    tick(10);

    // bounce: high 2, low 1, then high and held
    c = cyc;
    bus.btn_in = 1'b1;
    probe(c + 4, 1, 8'd1);
    probe(c + 5, 1, 8'd0);
    probe(c + 5, 2, g_exp(1));
    probe(c + 9, 0, 8'd0);
    probe(c + 11, 2, g_exp(1));
    exp_edge(c + 3 + LAT, 1'b1);
    tick(2);
    bus.btn_in = 1'b0;
    tick(1);
    bus.btn_in = 1'b1;
    tick(12);

    c = cyc;
    bus.btn_in = 1'b0;
    exp_edge(c + LAT, 1'b0);
    probe(c + 8, 2, g_exp(1));
    tick(10);

    // reset in the middle of a rising qualification
    c = cyc;
    bus.btn_in = 1'b1;
    probe(c + 4, 1, 8'd1);
    probe(c + 5, 0, 8'd0);
    probe(c + 5, 1, 8'd0);
    probe(c + 5, 2, 8'd0);
    probe(c + 11, 0, 8'd0);
    exp_edge(c + 5 + LAT, 1'b1);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);

    c = cyc;
    bus.btn_in = 1'b0;
    exp_edge(c + LAT, 1'b0);
    probe(c + 8, 2, 8'd0);
    tick(10);

    // glitch counter saturation with 1-cycle pulses every 3 cycles
    for (int i = 0; i < 300; i++) begin
      if (i == 100) probe(cyc + 2, 2, g_exp(100));
      bus.btn_in = 1'b1;
      tick(1);
      bus.btn_in = 1'b0;
      tick(2);
    end
    tick(5);
    probe(cyc + 1, 2, g_exp(300));
    probe(cyc + 1, 0, 8'd0);
    tick(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_edges: %0d btn_out edges never seen, expected 0", exp_q.size());
    end
    checks++;
    if (probe_q.size() != 0) begin
      errors++;
      $display("FAIL pending_probes: %0d probes not evaluated, expected 0", probe_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
